mem_dump_tx: RTL and testbench

- Serial transmitter that reads the CPU result-memory taps mem20..mem30 and sends them out one byte at a time.
- On a start request it captures all eleven words in one cycle, then shifts each out as a UART 8N1 frame on txd, in address order 20 to 30.
- Sits beside the CPU top level. Its inputs are wired directly to the memory's mem20..mem30 outputs.

---
 rtl/mem_dump_tx.sv | 187 ++++++++++++++++++
 tb/tb_mem_dump_tx.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mem_dump_tx.sv
// Serial dump of memory taps mem20..mem30 as back-to-back UART 8N1 frames.
// Optional MEM_DUMP_CHECKSUM_EN appends an 8-bit running-sum byte after the last word.
module mem_dump_tx #(
    parameter int CLK_DIV = 16,
    parameter int NWORDS  = 11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] mem20,
    input  logic [7:0] mem21,
    input  logic [7:0] mem22,
    input  logic [7:0] mem23,
    input  logic [7:0] mem24,
    input  logic [7:0] mem25,
    input  logic [7:0] mem26,
    input  logic [7:0] mem27,
    input  logic [7:0] mem28,
    input  logic [7:0] mem29,
    input  logic [7:0] mem30,
    output logic       txd,
    output logic       busy,
    output logic       done
);

    localparam int            CW     = $clog2(CLK_DIV);
    localparam logic [CW-1:0] DIV_M1 = CW'(CLK_DIV - 1);
`ifdef MEM_DUMP_CHECKSUM_EN
    localparam logic [3:0]    LAST_WORD = 4'(NWORDS);
`else
    localparam logic [3:0]    LAST_WORD = 4'(NWORDS - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [3:0]    word_q;
    logic [7:0]    shift_q;
    logic [7:0]    shadow_q [NWORDS];
    logic          txd_q;
    logic          busy_q;
    logic          done_q;
`ifdef MEM_DUMP_CHECKSUM_EN
    logic [7:0]    sum_q;
`endif

    logic [7:0]    mem_s [NWORDS];
    logic [3:0]    next_word_s;
    logic [7:0]    next_byte_s;

    assign mem_s[0]  = mem20;
    assign mem_s[1]  = mem21;
    assign mem_s[2]  = mem22;
    assign mem_s[3]  = mem23;
    assign mem_s[4]  = mem24;
    assign mem_s[5]  = mem25;
    assign mem_s[6]  = mem26;
    assign mem_s[7]  = mem27;
    assign mem_s[8]  = mem28;
    assign mem_s[9]  = mem29;
    assign mem_s[10] = mem30;

    // Byte that follows the current stop bit: next shadow word, or the checksum once words run out
    always_comb begin
        next_word_s = word_q + 4'd1;
        next_byte_s = 8'h00;
        if (next_word_s < 4'(NWORDS)) begin
            next_byte_s = shadow_q[next_word_s];
        end else begin
`ifdef MEM_DUMP_CHECKSUM_EN
            next_byte_s = sum_q;
`else
            next_byte_s = 8'h00;
`endif
        end
    end

    // Transmit FSM: capture, bit timing, framing and registered line/status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= {CW{1'b0}};
            bit_q   <= 3'd0;
            word_q  <= 4'd0;
            shift_q <= 8'h00;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < NWORDS; i++) begin
                shadow_q[i] <= 8'h00;
            end
`ifdef MEM_DUMP_CHECKSUM_EN
            sum_q   <= 8'h00;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        shadow_q <= mem_s;
                        shift_q  <= mem20;
                        word_q   <= 4'd0;
                        cnt_q    <= DIV_M1;
                        txd_q    <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= S_START;
`ifdef MEM_DUMP_CHECKSUM_EN
                        sum_q    <= mem20;
`endif
                    end
                end
                S_START: begin
                    if (cnt_q == {CW{1'b0}}) begin
                        cnt_q   <= DIV_M1;
                        bit_q   <= 3'd0;
                        txd_q   <= shift_q[0];
                        shift_q <= {1'b0, shift_q[7:1]};
                        state_q <= S_DATA;
                    end else begin
                        cnt_q <= cnt_q - {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                S_DATA: begin
                    if (cnt_q == {CW{1'b0}}) begin
                        cnt_q <= DIV_M1;
                        if (bit_q == 3'd7) begin
                            txd_q   <= 1'b1;
                            state_q <= S_STOP;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            txd_q   <= shift_q[0];
                            shift_q <= {1'b0, shift_q[7:1]};
                        end
                    end else begin
                        cnt_q <= cnt_q - {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                S_STOP: begin
                    if (cnt_q == {CW{1'b0}}) begin
                        if (word_q == LAST_WORD) begin
                            txd_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_FIN;
                        end else begin
                            cnt_q   <= DIV_M1;
                            word_q  <= next_word_s;
                            shift_q <= next_byte_s;
                            txd_q   <= 1'b0;
                            state_q <= S_START;
`ifdef MEM_DUMP_CHECKSUM_EN
                            if (next_word_s < 4'(NWORDS)) begin
                                sum_q <= sum_q + next_byte_s;
                            end else begin
                                sum_q <= sum_q;
                            end
`endif
                        end
                    end else begin
                        cnt_q <= cnt_q - {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    txd_q   <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign txd  = txd_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_mem_dump_tx.sv
// Self-checking bench for mem_dump_tx: vector table of dumps, UART decoder and byte scoreboard.
module tb_mem_dump_tx;

    localparam int DIV = 4;
`ifdef MEM_DUMP_CHECKSUM_EN
    localparam int NB = 12;
`else
    localparam int NB = 11;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] mem [11];
    logic       txd, busy, done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [10:0][7:0] d;
        logic [7:0]       cks;
    } vec_t;
    vec_t tbl [4];

    logic [7:0] dq [$];

    mem_dump_tx #(.CLK_DIV(DIV), .NWORDS(11)) dut (
        .clk(clk), .rst(rst), .start(start),
        .mem20(mem[0]), .mem21(mem[1]), .mem22(mem[2]), .mem23(mem[3]),
        .mem24(mem[4]), .mem25(mem[5]), .mem26(mem[6]), .mem27(mem[7]),
        .mem28(mem[8]), .mem29(mem[9]), .mem30(mem[10]),
        .txd(txd), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int v, input int i);
        if (i < 11) return tbl[v].d[i];
        return tbl[v].cks;
    endfunction

    // UART receiver: samples each bit mid-period and checks bytes against the scoreboard
    int         dec_t = 0;
    bit         dec_on = 1'b0;
    logic [7:0] dec_b;
    logic [7:0] exp_b;
    always @(negedge clk) begin
        if (rst) begin
            dec_on = 1'b0;
            dec_t  = 0;
        end else if (!dec_on) begin
            if (txd === 1'b0) begin
                dec_on = 1'b1;
                dec_t  = 0;
            end
        end else begin
            dec_t++;
            if ((dec_t % DIV) == DIV / 2 && dec_t / DIV >= 1 && dec_t / DIV <= 8)
                dec_b[dec_t / DIV - 1] = txd;
            if (dec_t == 9 * DIV + DIV / 2) begin
                chk("stop_bit", int'(txd), 1);
                if (dq.size() == 0) begin
                    chk("unexpected_byte", int'(dec_b), -1);
                end else begin
                    exp_b = dq.pop_front();
                    chk("rx_byte", int'(dec_b), int'(exp_b));
                end
                dec_on = 1'b0;
            end
        end
    end

    task automatic run_dump(input int v, input bit bitchk, input bit interfere);
        int         busy_n = 0;
        int         cyc = 0;
        int         extra_done = 0;
        bit         seen_done = 1'b0;
        bit         bits_ok = 1'b1;
        bit         idle_ok = 1'b1;
        logic [9:0] fr;
        @(negedge clk);
        for (int i = 0; i < 11; i++) mem[i] = tbl[v].d[i];
        start = 1'b1;
        for (int i = 0; i < NB; i++) dq.push_back(exp_byte(v, i));
        fr = {1'b1, tbl[v].d[0], 1'b0};
        @(negedge clk);
        start = 1'b0;
        while (!seen_done && cyc < 3000) begin
            if (bitchk && cyc < 10 * DIV && txd !== fr[cyc / DIV]) bits_ok = 1'b0;
            if (done === 1'b1) begin
                seen_done = 1'b1;
                chk("busy_at_done", int'(busy), 0);
                chk("txd_at_done", int'(txd), 1);
                if (interfere) start = 1'b1;
            end else if (busy === 1'b1) begin
                busy_n++;
            end
            if (interfere && cyc == 100) begin
                for (int i = 0; i < 11; i++) mem[i] = 8'hFF;
                start = 1'b1;
            end
            if (interfere && cyc == 101) start = 1'b0;
            cyc++;
            if (!seen_done) @(negedge clk);
        end
        chk("done_seen", int'(seen_done), 1);
        chk("busy_cycles", busy_n, NB * 10 * DIV);
        chk("all_bytes_rx", dq.size(), 0);
        if (bitchk) chk("frame_bits", int'(bits_ok), 1);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done === 1'b1) extra_done++;
            if (busy !== 1'b0 || txd !== 1'b1) idle_ok = 1'b0;
        end
        chk("done_once", extra_done, 0);
        chk("idle_after", int'(idle_ok), 1);
    endtask

    initial begin
        bit hold_ok = 1'b1;
        for (int i = 0; i < 11; i++) begin
            tbl[0].d[i] = 8'(i + 1);
            tbl[1].d[i] = 8'hFF;
            tbl[3].d[i] = 8'h00;
        end
        tbl[0].cks = 8'h42;
        tbl[1].cks = 8'hF5;
        tbl[2].d   = {8'h99, 8'hC3, 8'h33, 8'h20, 8'h10, 8'hFE,
                      8'h01, 8'h7F, 8'h80, 8'hAA, 8'h55};
        tbl[2].cks = 8'hBC;
        tbl[3].cks = 8'h00;
        for (int i = 0; i < 11; i++) mem[i] = 8'h00;

        #12 rst = 1'b1;
        #1;
        chk("rst_txd", int'(txd), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0 || done !== 1'b0) hold_ok = 1'b0;
        end
        chk("idle_hold", int'(hold_ok), 1);

        run_dump(2, 1'b1, 1'b0);
        run_dump(0, 1'b0, 1'b1);
        for (int v = 1; v < 4; v++) run_dump(v, 1'b0, 1'b0);

        @(negedge clk);
        for (int i = 0; i < 11; i++) mem[i] = tbl[0].d[i];
        start = 1'b1;
        for (int i = 0; i < NB; i++) dq.push_back(exp_byte(0, i));
        @(negedge clk);
        start = 1'b0;
        repeat (3 * 10 * DIV + 2 * DIV) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_txd", int'(txd), 1);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        dq.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_dump(2, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
